// File: rtl/word_loader.sv
// Splits a handshaked byte stream into NUL-terminated words in the word SRAM
// and holds each word for the matcher until it is released with match_done.
//
//   state     | meaning
//   COLLECT   | accept characters, write them at count, wait for a delimiter
//   TERMINATE | write the NUL at count
//   PRESENT   | word held for the matcher; input stalled until match_done
module word_loader #(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  word_valid,
  output logic [ADDR_WIDTH-1:0] word_len,
  output logic                  truncated,
  input  logic                  match_done
);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    TERMINATE = 2'd1,
    PRESENT   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CHAR_NL   = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CHAR_NUL  = '0;

  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  trunc;
  logic                  xfer;
  logic                  is_delim;
  logic                  room;

  assign in_ready = (state == COLLECT);
  assign xfer     = in_valid & in_ready;
  assign is_delim = (in_data == DELIM) || (in_data == CHAR_NL) || (in_data == CHAR_NUL);
  assign room     = (count != COUNT_MAX);

  // Write strobe is gated by rst_n so a write in flight is abandoned on reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = count;
    wr_data = in_data;
    if (rst_n) begin
      if (state == COLLECT && xfer && !is_delim && room) begin
        wr_en = 1'b1;
      end else if (state == TERMINATE) begin
        wr_en   = 1'b1;
        wr_data = CHAR_NUL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      count      <= '0;
      trunc      <= 1'b0;
      word_valid <= 1'b0;
      word_len   <= '0;
      truncated  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            if (!is_delim) begin
              if (room) count <= count + 1'b1;
              else      trunc <= 1'b1;
            end else if (count != '0) begin
              state <= TERMINATE;
            end
          end
        end
        TERMINATE: begin
          state     <= PRESENT;
          word_len  <= count;
          truncated <= trunc;
        end
        PRESENT: begin
          // word_valid rises one cycle into PRESENT, after the NUL has landed.
          if (match_done) begin
            state      <= COLLECT;
            count      <= '0;
            trunc      <= 1'b0;
            word_valid <= 1'b0;
            word_len   <= '0;
            truncated  <= 1'b0;
          end else begin
            word_valid <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_word_loader.sv
// Directed bench for word_loader: drives on the falling edge, checks #1 later.
module tb_word_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       word_valid;
  logic [3:0] word_len;
  logic       truncated;
  logic       match_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DELIM(8'h20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .word_valid(word_valid),
    .word_len  (word_len),
    .truncated (truncated),
    .match_done(match_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one character in COLLECT; it is taken at the next rising edge.
  task automatic send(input logic [7:0] d, input logic exp_wr, input logic [3:0] exp_addr);
    @(negedge clk);
    in_data    = d;
    in_valid   = 1'b1;
    match_done = 1'b0;
    #1;
    chk("send_ready", in_ready, 1);
    chk("send_wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("send_addr", wr_addr, exp_addr);
      chk("send_data", wr_data, d);
    end
    @(posedge clk);
  endtask

  task automatic nul_cycle(input logic [3:0] exp_addr);
    @(negedge clk);
    in_valid   = 1'b0;
    match_done = 1'b0;
    #1;
    chk("nul_ready", in_ready, 0);
    chk("nul_wr_en", wr_en, 1);
    chk("nul_addr", wr_addr, exp_addr);
    chk("nul_data", wr_data, 0);
    chk("nul_word_valid", word_valid, 0);
    @(posedge clk);
  endtask

  // First PRESENT cycle: no word_valid yet; the next cycle it is up.
  task automatic present(input logic [3:0] exp_len, input logic exp_trunc);
    @(negedge clk);
    #1;
    chk("pres0_word_valid", word_valid, 0);
    chk("pres0_ready", in_ready, 0);
    chk("pres0_wr_en", wr_en, 0);
    chk("pres0_len", word_len, exp_len);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pres_word_valid", word_valid, 1);
    chk("pres_len", word_len, exp_len);
    chk("pres_trunc", truncated, exp_trunc);
    chk("pres_ready", in_ready, 0);
    chk("pres_wr_en", wr_en, 0);
  endtask

  task automatic release_word();
    @(negedge clk);
    match_done = 1'b1;
    #1;
    chk("rel_word_valid_before", word_valid, 1);
    @(posedge clk);
    #1;
    match_done = 1'b0;
    chk("rel_word_valid", word_valid, 0);
    chk("rel_ready", in_ready, 1);
    chk("rel_len", word_len, 0);
    chk("rel_trunc", truncated, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    match_done = 1'b0;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_len", word_len, 0);
    chk("rst_trunc", truncated, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // "cat "
    send(8'h63, 1, 4'd0);
    send(8'h61, 1, 4'd1);
    send(8'h74, 1, 4'd2);
    send(8'h20, 0, 4'd0);
    nul_cycle(4'd3);
    present(4'd3, 0);
    release_word();

    // "  dog "
    send(8'h20, 0, 4'd0);
    send(8'h20, 0, 4'd0);
    send(8'h64, 1, 4'd0);
    send(8'h6F, 1, 4'd1);
    send(8'h67, 1, 4'd2);
    send(8'h20, 0, 4'd0);
    nul_cycle(4'd3);
    present(4'd3, 0);
    release_word();

    // 20 x 'a': last 5 dropped without stalling, NUL in the reserved slot
    for (int i = 0; i < 20; i++) send(8'h61, (i < 15), 4'(i));
    send(8'h20, 0, 4'd0);
    nul_cycle(4'd15);
    present(4'd15, 1);

    // "hi\n" offered while PRESENT is stalled
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_data  = 8'h68;
      in_valid = 1'b1;
      #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_wr_en", wr_en, 0);
      chk("stall_word_valid", word_valid, 1);
      @(posedge clk);
    end
    release_word();
    chk("post_rel_wr_en", wr_en, 1);
    chk("post_rel_addr", wr_addr, 0);
    send(8'h68, 1, 4'd0);

    // match_done pulsed in COLLECT must not disturb count
    @(negedge clk);
    in_valid   = 1'b0;
    match_done = 1'b1;
    #1;
    chk("md_collect_ready", in_ready, 1);
    chk("md_collect_word_valid", word_valid, 0);
    @(posedge clk);
    #1;
    chk("md_collect_len", word_len, 0);
    chk("md_collect_ready_after", in_ready, 1);
    send(8'h69, 1, 4'd1);
    send(8'h0A, 0, 4'd0);
    nul_cycle(4'd2);
    present(4'd2, 0);
    release_word();

    // reset in the middle of "cat "
    send(8'h63, 1, 4'd0);
    send(8'h61, 1, 4'd1);
    @(negedge clk);
    rst_n    = 1'b0;
    in_data  = 8'h74;
    in_valid = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_word_valid", word_valid, 0);
    chk("midrst_len", word_len, 0);
    chk("midrst_trunc", truncated, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    send(8'h6F, 1, 4'd0);
    send(8'h78, 1, 4'd1);
    send(8'h20, 0, 4'd0);
    nul_cycle(4'd2);
    present(4'd2, 0);
    release_word();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
